// File: rtl/p_encoder_pkg.sv
// Shared constants and helpers for the p_encoder priority encoder family.
package p_encoder_pkg;

    localparam int IN_W_DEFAULT = 8;

    // Reset values of the registered outputs.
    localparam int   OUT_RST_VAL = 0;
    localparam logic V_OUT_RST   = 1'b0;

    // Ceiling log2, usable in constant expressions for width derivation.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/p_encoder_comb.sv
// Combinational priority scan: index of the highest set request bit, plus
// an "any request" flag gated by the enable.
module p_encoder_comb
    import p_encoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int OUT_W = clog2_f(IN_W)
) (
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] idx,
    output logic             any
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        idx = '0;
        // Ascending scan: a later (higher) set bit overwrites, so the top one wins.
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                idx = OUT_W'(i);
            end
        end
        any = en & (|in);
    end

endmodule

// File: rtl/p_encoder_8_3.sv
// 8-to-3 priority encoder with enable, registered index and valid flag.
// Define P_ENCODER_CASCADE_EN to add the eo/gs cascade outputs.
module p_encoder_8_3
    import p_encoder_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT,
    localparam int OUT_W = clog2_f(IN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic             v_out,
    output logic [OUT_W-1:0] out
`ifdef P_ENCODER_CASCADE_EN
    ,
    output logic             eo,
    output logic             gs
`endif
);

    if (IN_W < 2 || (IN_W & (IN_W - 1)) != 0) begin : g_bad_in_w
        $error("p_encoder_8_3: IN_W must be a power of two and at least 2");
    end

    logic [OUT_W-1:0] idx;
    logic             any;

    logic [OUT_W-1:0] out_d, out_q;
    logic             v_out_d, v_out_q;

    p_encoder_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .en  (en),
        .in  (in),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        v_out_d = any;
        out_d   = any ? idx : OUT_W'(OUT_RST_VAL);
    end

    // NOTE: posedge rst in the sensitivity list makes the clear immediate; state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= OUT_W'(OUT_RST_VAL);
            v_out_q <= V_OUT_RST;
        end else begin
            out_q   <= out_d;
            v_out_q <= v_out_d;
        end
    end

    assign out   = out_q;
    assign v_out = v_out_q;

`ifdef P_ENCODER_CASCADE_EN
    logic eo_d, eo_q;
    logic gs_d, gs_q;

    always_comb begin
        eo_d = en & ~(|in);
        gs_d = any;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eo_q <= 1'b0;
            gs_q <= 1'b0;
        end else begin
            eo_q <= eo_d;
            gs_q <= gs_d;
        end
    end

    assign eo = eo_q;
    assign gs = gs_q;
`endif

`ifndef SYNTHESIS
    a_in_known : assert property (@(posedge clk) disable iff (rst) en |-> !$isunknown(in))
        else $error("p_encoder_8_3: X/Z on in while en=1");
`endif

endmodule

// File: tb/tb_p_encoder_8_3.sv
// Directed self-checking bench for p_encoder_8_3; expected values hand-computed.
// Define P_ENCODER_CASCADE_EN to also exercise the eo/gs outputs.
module tb_p_encoder_8_3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic       v_out;
    logic [2:0] out;
`ifdef P_ENCODER_CASCADE_EN
    logic       eo;
    logic       gs;
`endif

    int errors = 0;
    int checks = 0;

    p_encoder_8_3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .v_out (v_out),
        .out   (out)
`ifdef P_ENCODER_CASCADE_EN
        ,
        .eo    (eo),
        .gs    (gs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic en_v, input logic [7:0] in_v);
        @(negedge clk);
        en = en_v;
        in = in_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        in  = 8'hFF;
        #2;
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL reset_immediate: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL reset_hold_over_edge: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL reset_release_no_edge: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({v_out, out} !== 4'b1_111) begin
            errors++;
            $display("FAIL reset_first_edge_ff: got v_out,out=%b expected %b", {v_out, out}, 4'b1_111);
        end
    endtask

    task automatic test_sequence;
        logic [7:0] vec [4]  = '{8'd39, 8'd24, 8'd172, 8'd108};
        logic [2:0] expv [4] = '{3'd5, 3'd4, 3'd7, 3'd6};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vec[i]);
            checks++;
            if ({v_out, out} !== {1'b1, expv[i]}) begin
                errors++;
                $display("FAIL seq_%0d in=%0d: got v_out,out=%b expected %b",
                         i, vec[i], {v_out, out}, {1'b1, expv[i]});
            end
        end
        // Latency: a new input must not show before the next edge.
        @(negedge clk);
        in = 8'h01;
        #2;
        checks++;
        if ({v_out, out} !== 4'b1_110) begin
            errors++;
            $display("FAIL latency_hold: got v_out,out=%b expected %b", {v_out, out}, 4'b1_110);
        end
    endtask

    task automatic test_walking_one;
        logic [7:0] vec;
        logic [2:0] expv;
        for (int i = 0; i < 8; i++) begin
            vec  = 8'h01 << i;
            expv = 3'(i);
            step(1'b1, vec);
            checks++;
            if ({v_out, out} !== {1'b1, expv}) begin
                errors++;
                $display("FAIL walk_%0d in=%h: got v_out,out=%b expected %b", i, vec, {v_out, out}, {1'b1, expv});
            end
        end
        step(1'b1, 8'h8F);
        checks++;
        if ({v_out, out} !== 4'b1_111) begin
            errors++;
            $display("FAIL msb_with_low_bits: got v_out,out=%b expected %b", {v_out, out}, 4'b1_111);
        end
        step(1'b1, 8'h03);
        checks++;
        if ({v_out, out} !== 4'b1_001) begin
            errors++;
            $display("FAIL in_03: got v_out,out=%b expected %b", {v_out, out}, 4'b1_001);
        end
    endtask

    task automatic test_disable;
        step(1'b0, 8'd6);
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL disabled_in6: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
        step(1'b1, 8'd1);
        checks++;
        if ({v_out, out} !== 4'b1_000) begin
            errors++;
            $display("FAIL lsb_only_valid: got v_out,out=%b expected %b", {v_out, out}, 4'b1_000);
        end
        step(1'b0, 8'hFF);
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL disabled_inFF: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
    endtask

    task automatic test_zero;
        step(1'b1, 8'd84);
        checks++;
        if ({v_out, out} !== 4'b1_110) begin
            errors++;
            $display("FAIL in84: got v_out,out=%b expected %b", {v_out, out}, 4'b1_110);
        end
        step(1'b1, 8'd0);
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL in_zero: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 8'h45);
        checks++;
        if ({v_out, out} !== 4'b1_110) begin
            errors++;
            $display("FAIL pre_async_reset: got v_out,out=%b expected %b", {v_out, out}, 4'b1_110);
        end
        // Assert between edges: negedge has passed, next posedge is 4 units away.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({v_out, out} !== 4'b0_000) begin
            errors++;
            $display("FAIL async_reset_clear: got v_out,out=%b expected %b", {v_out, out}, 4'b0_000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({v_out, out} !== 4'b1_110) begin
            errors++;
            $display("FAIL post_async_reset: got v_out,out=%b expected %b", {v_out, out}, 4'b1_110);
        end
    endtask

`ifdef P_ENCODER_CASCADE_EN
    task automatic test_cascade;
        step(1'b1, 8'h00);
        checks++;
        if ({eo, gs, v_out, out} !== 6'b10_0_000) begin
            errors++;
            $display("FAIL cascade_zero: got eo,gs,v_out,out=%b expected %b", {eo, gs, v_out, out}, 6'b10_0_000);
        end
        step(1'b1, 8'h10);
        checks++;
        if ({eo, gs, v_out, out} !== 6'b01_1_100) begin
            errors++;
            $display("FAIL cascade_0x10: got eo,gs,v_out,out=%b expected %b", {eo, gs, v_out, out}, 6'b01_1_100);
        end
        step(1'b0, 8'h00);
        checks++;
        if ({eo, gs} !== 2'b00) begin
            errors++;
            $display("FAIL cascade_disabled: got eo,gs=%b expected %b", {eo, gs}, 2'b00);
        end
        @(negedge clk);
        en = 1'b1;
        in = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({eo, gs} !== 2'b00) begin
            errors++;
            $display("FAIL cascade_reset: got eo,gs=%b expected %b", {eo, gs}, 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_walking_one();
        test_disable();
        test_zero();
        test_async_reset();
`ifdef P_ENCODER_CASCADE_EN
        test_cascade();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/p_encoder_8_3.md
Name: p_encoder_8_3

Overview:
- 8-input to 3-bit priority encoder with enable and valid flag; bit 7 has highest priority.
- Encoded result is registered, giving one clock of latency.
- Sits between request/flag vectors and downstream index consumers, e.g. interrupt or arbitration index selection.

Parameters:
- IN_W, 8, number of request inputs; must be a power of two, at least 2.
- OUT_W, $clog2(IN_W) = 3, encoded index width; localparam derived from IN_W, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  encoder enable; 0 forces an invalid/zero result
- in  input  IN_W  request vector; bit IN_W-1 has highest priority
- v_out  output  1  registered valid; 1 when en=1 and in has at least one bit set
- out  output  OUT_W  registered index of the highest set bit of in

Behaviour:
- Reset: rst=1 asynchronously forces out=0 and v_out=0; both hold until the first rising clk edge after rst deasserts.
- Combinational stage: scan from bit IN_W-1 down to 0; idx = position of the first 1 found.
- Register stage: at each rising clk edge with rst=0:
  - en=1 and in!=0: out<=idx, v_out<=1.
  - en=1 and in==0: out<=0, v_out<=0.
  - en=0: out<=0, v_out<=0 regardless of in.
- Latency: exactly 1 cycle from in/en sampled at an edge to out/v_out.
- No handshake; a new result every cycle. Outputs change only on the clk edge or on rst.
- Boundaries:
  - in=0x01 with en=1 gives out=0, v_out=1. This is distinguishable from the invalid case only via v_out.
  - in=0x80 gives out=7 regardless of the lower bits.
  - in=0xFF gives out=7.
  - rst asserted mid-stream clears the outputs immediately, without waiting for a clock edge.
- X/Z on in or en while en=1 is outside the contract; the result is unspecified. A simulation-only assertion, excluded under synthesis, shall flag any X/Z on in while en=1 and rst=0.

Optional Feature:
- Macro P_ENCODER_CASCADE_EN adds two registered outputs, eo and gs, for cascading encoders.
- eo (enable-out): 1 when en=1 and in==0, so the next lower-priority encoder may proceed.
- gs (group-select): 1 when en=1 and in!=0; equal to v_out.
- Both reset to 0 and follow the same 1-cycle latency as out/v_out.
- Without the macro: eo and gs ports and their logic are absent; the port list is exactly the six ports above.

Decomposition:
- Package p_encoder_pkg: default IN_W constant, an OUT_W helper function (clog2), and the reset values of out and v_out.
- One sub-module, p_encoder_comb: purely combinational. Inputs: en, in. Outputs: idx, any (reduction-OR gated by en).
- The top level, p_encoder_8_3, adds the output registers, the async reset, the optional cascade flags and the assertion.

Test Plan:
- rst=1 with en=1, in=0xFF -> out=0, v_out=0 immediately. Release rst; next edge -> out=7, v_out=1.
- en=1 sequence in=39, 24, 172, 108, one per cycle -> out=5, 4, 7, 6 respectively, each 1 cycle later, v_out=1 throughout.
- en=0, in=6 -> out=0, v_out=0. Next cycle en=1, in=1 -> out=0, v_out=1.
- en=1, in=84 -> out=6, v_out=1. Then in=0 -> out=0, v_out=0.
- Assert rst between clock edges while v_out=1 -> outputs clear at once, with no clock edge required.
- With P_ENCODER_CASCADE_EN defined: en=1, in=0 -> eo=1, gs=0. Then in=0x10 -> eo=0, gs=1, out=4.
